// File: rtl/jt12_wrseq.sv
// YM2612-style register write sequencer: queues {part,reg,val} commands and
// plays them out as address/data toggle-strobe accesses with busy polling.
module jt12_wrseq #(
    parameter int GAP       = 4,
    parameter int BUSY_TO   = 255,
    parameter bit SKIP_ADDR = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_part,
    input  logic [7:0] cmd_reg,
    input  logic [7:0] cmd_val,
    input  logic       flush,
    output logic [1:0] addr,
    output logic [7:0] dout,
    output logic       write,
    input  logic       busy,
    output logic       idle,
    output logic [2:0] level,
    output logic       err_to
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_AGAP,
        S_DATA,
        S_DGAP,
        S_WBUSY
    } state_t;

    localparam logic [3:0] GAP_LAST = 4'(GAP - 1);
    localparam logic [7:0] TO_LAST  = 8'(BUSY_TO - 1);
    localparam logic [7:0] TO_MAX   = 8'(BUSY_TO);

    state_t state, state_nx;

    logic [16:0] mem [4];
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  count;
    logic        push, pop;
    logic [16:0] head;
    logic        skip_hit;

    logic [3:0]  gap_cnt;
    logic [7:0]  to_cnt;
    logic [8:0]  last_addr;
    logic        last_valid;
    logic        cur_part;
    logic [7:0]  cur_reg, cur_val;

    logic        do_addr, do_data, to_hit, gap_done;

    assign head      = mem[rd_ptr];
    assign cmd_ready = (count != 3'd4);
    assign level     = count;
    assign push      = cmd_valid && cmd_ready && !flush;
    assign pop       = (state == S_IDLE) && (count != 3'd0) && !flush;
    assign skip_hit  = SKIP_ADDR && last_valid && (head[16:8] == last_addr);
    assign gap_done  = (gap_cnt == GAP_LAST);

    // Command FIFO; flush wins over a same-cycle push
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {cmd_part, cmd_reg, cmd_val};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= 3'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            count <= count + {2'b00, push} - {2'b00, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (pop) state_nx = skip_hit ? S_DATA : S_ADDR;
            S_ADDR:  state_nx = S_AGAP;
            S_AGAP:  if (gap_done) state_nx = S_DATA;
            S_DATA:  state_nx = S_DGAP;
            S_DGAP:  if (gap_done) state_nx = S_WBUSY;
            S_WBUSY: if (!busy || to_cnt == TO_LAST) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        idle    = (state == S_IDLE) && (count == 3'd0);
        do_addr = (state == S_ADDR);
        do_data = (state == S_DATA);
        to_hit  = (state == S_WBUSY) && busy && (to_cnt == TO_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            write      <= 1'b0;
            addr       <= 2'd0;
            dout       <= 8'd0;
            gap_cnt    <= 4'd0;
            to_cnt     <= 8'd0;
            last_addr  <= 9'd0;
            last_valid <= 1'b0;
            err_to     <= 1'b0;
            cur_part   <= 1'b0;
            cur_reg    <= 8'd0;
            cur_val    <= 8'd0;
        end else begin
            if (pop) begin
                cur_part <= head[16];
                cur_reg  <= head[15:8];
                cur_val  <= head[7:0];
            end
            if (do_addr) begin
                addr       <= {cur_part, 1'b0};
                dout       <= cur_reg;
                write      <= ~write;
                last_addr  <= {cur_part, cur_reg};
                last_valid <= 1'b1;
            end
            if (do_data) begin
                addr  <= {cur_part, 1'b1};
                dout  <= cur_val;
                write <= ~write;
            end
            if (do_addr || do_data)
                gap_cnt <= 4'd0;
            else if (state == S_AGAP || state == S_DGAP)
                gap_cnt <= gap_cnt + 4'd1;
            // Busy-wait budget restarts for every access
            if (state == S_DGAP)
                to_cnt <= 8'd0;
            else if (state == S_WBUSY && busy && to_cnt != TO_MAX)
                to_cnt <= to_cnt + 8'd1;
            if (to_hit) err_to <= 1'b1;
        end
    end

endmodule

// File: tb/tb_jt12_wrseq.sv
// Testbench for jt12_wrseq: directed vector table, corner sequences and a
// randomized run checked against a command-stream reference model.
module tb_jt12_wrseq;

    localparam int GAP = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_part = 1'b0;
    logic [7:0] cmd_reg = 8'd0;
    logic [7:0] cmd_val = 8'd0;
    logic       flush = 1'b0;
    logic [1:0] addr;
    logic [7:0] dout;
    logic       write;
    logic       busy;
    logic       idle;
    logic [2:0] level;
    logic       err_to;

    logic busy_man = 1'b0;
    logic bmode = 1'b0;
    int   bcnt = 0;

    assign busy = bmode ? (bcnt != 0) : busy_man;

    always #5 clk = ~clk;

    jt12_wrseq #(.GAP(GAP), .BUSY_TO(255), .SKIP_ADDR(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_part(cmd_part), .cmd_reg(cmd_reg), .cmd_val(cmd_val),
        .flush(flush), .addr(addr), .dout(dout), .write(write),
        .busy(busy), .idle(idle), .level(level), .err_to(err_to)
    );

    int checks = 0;
    int errors = 0;
    int stalls = 0;
    int cyc = 0;

    logic [9:0]  obs[$];
    int          obs_t[$];
    logic [16:0] mq[$];
    logic        mlv = 1'b0;
    logic [8:0]  mla = 9'd0;
    logic        prev_w = 1'b0;

    // Record every write toggle as {addr,dout}; reset edges are not accesses
    always @(posedge clk) begin
        logic r;
        r = rst_n;
        #1;
        cyc++;
        if (!r) begin
            prev_w = write;
        end else if (write != prev_w) begin
            prev_w = write;
            obs.push_back({addr, dout});
            obs_t.push_back(cyc);
            if (bmode && addr[0]) bcnt = 20;
        end else if (bcnt > 0) begin
            bcnt--;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        flush = 1'b0;
        bmode = 1'b0;
        busy_man = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        obs.delete();
        obs_t.delete();
        mq.delete();
        mlv = 1'b0;
        mla = 9'd0;
    endtask

    task automatic push1(input logic p, input logic [7:0] r,
                         input logic [7:0] v);
        int g;
        logic acc;
        cmd_valid = 1'b1;
        cmd_part = p;
        cmd_reg = r;
        cmd_val = v;
        g = 0;
        acc = 1'b0;
        while (!acc && g < 1000) begin
            acc = cmd_ready;
            if (!acc) stalls++;
            @(negedge clk);
            g++;
        end
        cmd_valid = 1'b0;
        if (!acc) chk("push_timeout", 32'd0, 32'd1);
        else mq.push_back({p, r, v});
    endtask

    task automatic wait_idle(input int lim, output int n);
        n = 0;
        while (!idle && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (!idle) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_obs(input int cnt, input int lim);
        int n;
        n = 0;
        while (obs.size() < cnt && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (obs.size() < cnt) chk("toggle_timeout", 32'(obs.size()), 32'(cnt));
    endtask

    // Expected access stream: address phase unless the same {part,reg}
    // was the last address written, then always a data phase.
    task automatic compare_model(input string name);
        logic [9:0] exp[$];
        logic [16:0] c;
        int n;
        foreach (mq[i]) begin
            c = mq[i];
            if (!(mlv && mla == c[16:8]))
                exp.push_back({c[16], 1'b0, c[15:8]});
            exp.push_back({c[16], 1'b1, c[7:0]});
            mla = c[16:8];
            mlv = 1'b1;
        end
        chk($sformatf("%s_count", name), 32'(obs.size()), 32'(exp.size()));
        n = (obs.size() < exp.size()) ? obs.size() : exp.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s[%0d]", name, i), 32'(obs[i]), 32'(exp[i]));
        mq.delete();
        obs.delete();
        obs_t.delete();
    endtask

    typedef struct {
        logic       p;
        logic [7:0] r;
        logic [7:0] v;
        int         ntog;
        logic [9:0] first;
        logic [9:0] last;
        int         lat;
    } vec_t;

    vec_t tv[6];
    logic [7:0] rtab[4];

    initial begin
        int n, td;
        logic acc;

        tv[0] = '{1'b0, 8'h28, 8'hF0, 2, 10'h028, 10'h1F0, 2*GAP+4};
        tv[1] = '{1'b1, 8'hA4, 8'h22, 2, 10'h2A4, 10'h322, 2*GAP+4};
        tv[2] = '{1'b1, 8'hA4, 8'h23, 1, 10'h323, 10'h323, GAP+3};
        tv[3] = '{1'b0, 8'hA4, 8'h01, 2, 10'h0A4, 10'h101, 2*GAP+4};
        tv[4] = '{1'b0, 8'hA4, 8'h02, 1, 10'h102, 10'h102, GAP+3};
        tv[5] = '{1'b0, 8'hB0, 8'h33, 2, 10'h0B0, 10'h133, 2*GAP+4};
        rtab[0] = 8'h28;
        rtab[1] = 8'hA4;
        rtab[2] = 8'h30;
        rtab[3] = 8'hB4;

        do_reset();
        chk("rst_write", 32'(write), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_err", 32'(err_to), 32'd0);

        // Isolated commands, busy clear
        for (int i = 0; i < 6; i++) begin
            obs.delete();
            obs_t.delete();
            push1(tv[i].p, tv[i].r, tv[i].v);
            wait_idle(100, n);
            chk($sformatf("vec%0d_lat", i), 32'(n), 32'(tv[i].lat));
            chk($sformatf("vec%0d_ntog", i), 32'(obs.size()), 32'(tv[i].ntog));
            if (obs.size() >= 1) begin
                chk($sformatf("vec%0d_first", i), 32'(obs[0]), 32'(tv[i].first));
                chk($sformatf("vec%0d_last", i), 32'(obs[obs.size()-1]),
                    32'(tv[i].last));
            end
            if (obs.size() == 2)
                chk($sformatf("vec%0d_gap", i), 32'(obs_t[1] - obs_t[0]),
                    32'(GAP + 1));
        end

        // Back-to-back with long busy after each data write
        do_reset();
        bmode = 1'b1;
        stalls = 0;
        for (int i = 0; i < 5; i++)
            push1(i[0], 8'h10 + 8'(i), 8'h11 * 8'(i) + 8'h01);
        chk("full_level", 32'(level), 32'd4);
        chk("full_ready", 32'(cmd_ready), 32'd0);
        push1(1'b1, 8'h20, 8'h5A);
        chk("full_stalled", 32'(stalls > 0), 32'd1);
        wait_idle(3000, n);
        bmode = 1'b0;
        compare_model("b2b");

        // Flush during the address gap with three entries queued
        do_reset();
        for (int i = 0; i < 4; i++)
            push1(1'b0, 8'h40 + 8'(i), 8'h70 + 8'(i));
        chk("flush_pre_level", 32'(level), 32'd3);
        chk("flush_in_agap", 32'(obs.size()), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_level", 32'(level), 32'd0);
        wait_idle(100, n);
        repeat (30) @(negedge clk);
        chk("flush_ntog", 32'(obs.size()), 32'd2);
        if (obs.size() >= 2) begin
            chk("flush_addr_ph", 32'(obs[0]), 32'h040);
            chk("flush_data_ph", 32'(obs[1]), 32'h170);
        end

        // Reset during the data gap
        do_reset();
        push1(1'b1, 8'h55, 8'hAA);
        wait_obs(2, 100);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_addr", 32'(addr), 32'd0);
        chk("mid_rst_dout", 32'(dout), 32'd0);
        chk("mid_rst_write", 32'(write), 32'd0);
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_idle", 32'(idle), 32'd1);
        chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("mid_rst_ntog", 32'(obs.size()), 32'd2);

        // Busy stuck high: timeout, then the next command still issues
        do_reset();
        busy_man = 1'b1;
        push1(1'b0, 8'h28, 8'h01);
        wait_obs(2, 100);
        td = (obs_t.size() >= 2) ? obs_t[1] : 0;
        n = 0;
        while (!err_to && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("err_delay", 32'(cyc - td), 32'(GAP + 255));
        chk("err_idle", 32'(idle), 32'd1);
        busy_man = 1'b0;
        push1(1'b0, 8'h28, 8'h02);
        wait_idle(100, n);
        chk("err_sticky", 32'(err_to), 32'd1);
        compare_model("after_to");

        // Randomized traffic against the stream model
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            cmd_valid = ($urandom % 3) != 0;
            cmd_part = 1'($urandom);
            cmd_reg = rtab[$urandom % 4];
            cmd_val = 8'($urandom);
            busy_man = ($urandom % 10) < 6;
            acc = cmd_valid && cmd_ready;
            @(negedge clk);
            if (acc) mq.push_back({cmd_part, cmd_reg, cmd_val});
        end
        cmd_valid = 1'b0;
        busy_man = 1'b0;
        wait_idle(1000, n);
        chk("rand_level", 32'(level), 32'd0);
        chk("rand_err", 32'(err_to), 32'd0);
        compare_model("rand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
